// File: rtl/acc_job_sequencer.sv
// Job sequencer for the accumulator: configures it once per tile, meters iters*reads input beats
// and counts reads output beats per tile. Optional watchdog: ACC_SEQ_TIMEOUT_EN.
module acc_job_sequencer #(
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    parameter int LOG_MAX_TILES          = 16,
    parameter int TIMEOUT_CYCLES         = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [LOG_MAX_TILES-1:0]          cfg_num_tiles,
    input  logic [LOG_MAX_ITERS-1:0]          cfg_num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] cfg_num_reads_per_iter,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [LOG_MAX_TILES-1:0]          tile_idx,
    output logic                              acc_configure,
    output logic [LOG_MAX_ITERS-1:0]          acc_num_iters,
    output logic [LOG_MAX_READS_PER_ITER-1:0] acc_num_reads_per_iter,
    input  logic                              up_valid,
    output logic                              up_avail,
    output logic                              acc_valid_in,
    input  logic                              acc_avail_out,
    input  logic                              acc_valid_out
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONFIG = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    localparam int CNT_W = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER;

    logic [1:0]                        state;
    logic [LOG_MAX_TILES-1:0]          num_tiles;
    logic [CNT_W-1:0]                  in_cnt;
    logic [LOG_MAX_READS_PER_ITER-1:0] out_cnt;
    logic                              gate;
    logic                              in_beat;
    logic                              out_beat;
    logic                              last_out;
    logic                              timeout;

    // Handshake: a beat transfers on a cycle where valid and avail are both high; the gate
    // forces both directions low once the tile's input quota is used up or outside RUN.
    assign gate          = (state == S_RUN) && (in_cnt != '0);
    assign acc_valid_in  = up_valid & gate;
    assign up_avail      = acc_avail_out & gate;
    assign in_beat       = up_valid & acc_avail_out & gate;
    assign out_beat      = (state == S_RUN) & acc_valid_out;
    assign last_out      = out_beat && (out_cnt == LOG_MAX_READS_PER_ITER'(1));
    assign busy          = (state == S_CONFIG) || (state == S_RUN);
    assign done          = (state == S_DONE);
    assign acc_configure = (state == S_CONFIG);

`ifdef ACC_SEQ_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog;
    logic              err_q;

    assign timeout = (state == S_RUN) && !in_beat && !out_beat
                     && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
    assign error   = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state != S_RUN) || in_beat || out_beat) wdog <= '0;
            else                                         wdog <= wdog + WDOG_W'(1);
            if (timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                  <= S_IDLE;
            num_tiles              <= '0;
            tile_idx               <= '0;
            acc_num_iters          <= '0;
            acc_num_reads_per_iter <= '0;
            in_cnt                 <= '0;
            out_cnt                <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_tiles              <= cfg_num_tiles;
                        acc_num_iters          <= cfg_num_iters;
                        acc_num_reads_per_iter <= cfg_num_reads_per_iter;
                        tile_idx               <= '0;
                        if ((cfg_num_tiles == '0) || (cfg_num_iters == '0)
                            || (cfg_num_reads_per_iter == '0))
                            state <= S_DONE;
                        else
                            state <= S_CONFIG;
                    end
                end
                S_CONFIG: begin
                    // Zero-extend both factors so the full product fits in CNT_W bits.
                    in_cnt  <= {{LOG_MAX_READS_PER_ITER{1'b0}}, acc_num_iters}
                               * {{LOG_MAX_ITERS{1'b0}}, acc_num_reads_per_iter};
                    out_cnt <= acc_num_reads_per_iter;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (in_beat)  in_cnt  <= in_cnt - CNT_W'(1);
                    if (out_beat) out_cnt <= out_cnt - LOG_MAX_READS_PER_ITER'(1);
                    if (timeout) begin
                        state <= S_DONE;
                    end else if (last_out) begin
                        if (tile_idx == num_tiles - LOG_MAX_TILES'(1)) begin
                            state <= S_DONE;
                        end else begin
                            tile_idx <= tile_idx + LOG_MAX_TILES'(1);
                            state    <= S_CONFIG;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_job_sequencer.sv
// Self-checking bench for acc_job_sequencer: per-job reference model built from the tile/beat
// rules plus a simple accumulator model; the watchdog test runs when ACC_SEQ_TIMEOUT_EN is set.
module tb_acc_job_sequencer;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cfg_num_tiles;
    logic [15:0] cfg_num_iters;
    logic [15:0] cfg_num_reads_per_iter;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] tile_idx;
    logic        acc_configure;
    logic [15:0] acc_num_iters;
    logic [15:0] acc_num_reads_per_iter;
    logic        up_valid;
    logic        up_avail;
    logic        acc_valid_in;
    logic        acc_avail_out;
    logic        acc_valid_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    acc_job_sequencer #(
        .LOG_MAX_ITERS(16),
        .LOG_MAX_READS_PER_ITER(16),
        .LOG_MAX_TILES(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_num_tiles(cfg_num_tiles),
        .cfg_num_iters(cfg_num_iters),
        .cfg_num_reads_per_iter(cfg_num_reads_per_iter),
        .busy(busy),
        .done(done),
        .error(error),
        .tile_idx(tile_idx),
        .acc_configure(acc_configure),
        .acc_num_iters(acc_num_iters),
        .acc_num_reads_per_iter(acc_num_reads_per_iter),
        .up_valid(up_valid),
        .up_avail(up_avail),
        .acc_valid_in(acc_valid_in),
        .acc_avail_out(acc_avail_out),
        .acc_valid_out(acc_valid_out)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_cfg"}, acc_configure, 0);
        check({tag, "_up_avail"}, up_avail, 0);
        check({tag, "_valid_in"}, acc_valid_in, 0);
        check({tag, "_tile_idx"}, tile_idx, 0);
        check({tag, "_acc_iters"}, acc_num_iters, 0);
        check({tag, "_acc_reads"}, acc_num_reads_per_iter, 0);
    endtask

    // Driver + model: runs one job, checks every cycle, returns observed beat counts.
    task automatic run_job(input int tiles, input int iters, input int reads, input bit rnd,
                           output int n_acc, output int n_cfg, output int n_out,
                           output int n_acc_pre2);
        int  tile_beats;
        int  m_in, m_out, m_tile;
        bit  m_cfg_next, m_done_next, m_active, m_run, gate, finished;
        bit  exp_cfg, exp_done, exp_busy;
        int  acc_in, acc_out, owed;
        logic [15:0] want;
        tile_beats = iters * reads;
        n_acc = 0; n_cfg = 0; n_out = 0; n_acc_pre2 = 0;
        m_in = 0; m_out = 0; m_tile = 0; acc_in = 0; acc_out = 0;
        m_cfg_next = 0; m_done_next = 0; m_active = 0; finished = 0;

        @(negedge clk);
        start = 1'b1;
        cfg_num_tiles = 16'(tiles);
        cfg_num_iters = 16'(iters);
        cfg_num_reads_per_iter = 16'(reads);
        up_valid = 1'b1;
        acc_avail_out = 1'b1;
        acc_valid_out = 1'b0;
        #1;
        check("start_busy", busy, 0);
        check("start_cfg", acc_configure, 0);
        check("start_up_avail", up_avail, 0);
        if (tiles == 0 || iters == 0 || reads == 0) begin
            m_done_next = 1;
        end else begin
            m_cfg_next = 1;
            m_active = 1;
            for (int t = 0; t < tiles; t++) exp_q.push_back(16'(t));
        end

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (rnd) begin
                up_valid = ($urandom_range(0, 3) != 0);
                acc_avail_out = ($urandom_range(0, 3) != 0);
            end else begin
                up_valid = 1'b1;
                acc_avail_out = 1'b1;
            end
            // Accumulator emits results only once the last iteration's reads arrive.
            owed = (acc_in > (iters - 1) * reads) ? acc_in - (iters - 1) * reads - acc_out : 0;
            acc_valid_out = (owed > 0) && (!rnd || $urandom_range(0, 1) == 1);
            #1;
            exp_cfg  = m_cfg_next;
            exp_done = m_done_next;
            exp_busy = m_active;
            m_run = m_active && !exp_cfg;
            gate = m_run && (m_in < tile_beats);
            check("cfg_pulse", acc_configure, exp_cfg);
            check("done_pulse", done, exp_done);
            check("busy", busy, exp_busy);
            check("error", error, 0);
            check("up_avail", up_avail, acc_avail_out & gate);
            check("valid_in", acc_valid_in, up_valid & gate);
            if (m_active) check("tile_idx", tile_idx, 16'(m_tile));

            // Scoreboard: each configure pulse must match the next expected tile.
            if (acc_configure) begin
                n_cfg++;
                acc_in = 0;
                acc_out = 0;
                check("acc_iters", acc_num_iters, 16'(iters));
                check("acc_reads", acc_num_reads_per_iter, 16'(reads));
                if (exp_q.size() == 0) begin
                    check("cfg_extra", 1, 0);
                end else begin
                    want = exp_q.pop_front();
                    check("cfg_tile", tile_idx, want);
                end
            end
            if (exp_cfg) begin
                m_in = 0;
                m_out = 0;
            end
            if (acc_valid_in && acc_avail_out) begin
                n_acc++;
                acc_in++;
                if (n_cfg < 2) n_acc_pre2++;
            end
            if (acc_valid_out) acc_out++;

            m_cfg_next = 0;
            m_done_next = 0;
            if (gate && up_valid && acc_avail_out) m_in++;
            if (m_run && acc_valid_out) begin
                m_out++;
                n_out++;
                if (m_out == reads) begin
                    if (m_tile == tiles - 1) begin
                        m_done_next = 1;
                        m_active = 0;
                    end else begin
                        m_tile++;
                        m_cfg_next = 1;
                    end
                end
            end
            if (exp_done) finished = 1;
        end
        check("job_finished", finished, 1);
        check("cfg_missing", exp_q.size(), 0);
        exp_q.delete();

        // Idle afterwards: stray output valids are ignored and nothing is gated in.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            up_valid = 1'b1;
            acc_avail_out = 1'b1;
            acc_valid_out = 1'b1;
            #1;
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_cfg", acc_configure, 0);
            check("idle_up_avail", up_avail, 0);
            check("idle_valid_in", acc_valid_in, 0);
        end
        acc_valid_out = 1'b0;
    endtask

    initial begin
        int n_acc, n_cfg, n_out, n_pre2, cnt;
        int r_t, r_i, r_r;
        bit got_done;
        int run_cycles;
        rst = 1'b0;
        start = 1'b0;
        cfg_num_tiles = '0;
        cfg_num_iters = '0;
        cfg_num_reads_per_iter = '0;
        up_valid = 1'b1;
        acc_avail_out = 1'b1;
        acc_valid_out = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        run_job(1, 2, 3, 0, n_acc, n_cfg, n_out, n_pre2);
        check("t1_cfgs", n_cfg, 1);
        check("t1_beats", n_acc, 6);
        check("t1_outs", n_out, 3);

        run_job(3, 1, 4, 0, n_acc, n_cfg, n_out, n_pre2);
        check("t2_cfgs", n_cfg, 3);
        check("t2_beats", n_acc, 12);
        check("t2_outs", n_out, 12);

        run_job(2, 0, 3, 0, n_acc, n_cfg, n_out, n_pre2);
        check("t3_iters0_cfgs", n_cfg, 0);
        check("t3_iters0_beats", n_acc, 0);
        run_job(0, 2, 2, 0, n_acc, n_cfg, n_out, n_pre2);
        check("t3_tiles0_cfgs", n_cfg, 0);
        run_job(1, 2, 0, 0, n_acc, n_cfg, n_out, n_pre2);
        check("t3_reads0_cfgs", n_cfg, 0);

        run_job(2, 4, 5, 1, n_acc, n_cfg, n_out, n_pre2);
        check("t4_cfgs", n_cfg, 2);
        check("t4_beats", n_acc, 40);
        check("t4_pre2_le_20", n_pre2 <= 20, 1);

        // Abort mid-RUN after 7 accepted beats.
        @(negedge clk);
        start = 1'b1;
        cfg_num_tiles = 16'd1;
        cfg_num_iters = 16'd4;
        cfg_num_reads_per_iter = 16'd4;
        up_valid = 1'b1;
        acc_avail_out = 1'b1;
        acc_valid_out = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 7; c++) begin
            #1;
            if (acc_valid_in && acc_avail_out) cnt++;
            @(negedge clk);
        end
        check("t5_beats_before_abort", cnt, 7);
        check("t5_busy_before_abort", busy, 1);
        rst = 1'b0;
        #1;
        check_all_zero("t5_abort");
        @(negedge clk);
        rst = 1'b1;
        run_job(1, 1, 2, 0, n_acc, n_cfg, n_out, n_pre2);
        check("t5_restart_beats", n_acc, 2);
        check("t5_restart_outs", n_out, 2);

        for (int j = 0; j < 6; j++) begin
            r_t = $urandom_range(1, 3);
            r_i = $urandom_range(1, 3);
            r_r = $urandom_range(1, 4);
            run_job(r_t, r_i, r_r, 1, n_acc, n_cfg, n_out, n_pre2);
            check("rnd_cfgs", n_cfg, r_t);
            check("rnd_beats", n_acc, r_t * r_i * r_r);
            check("rnd_outs", n_out, r_t * r_r);
        end

`ifdef ACC_SEQ_TIMEOUT_EN
        @(negedge clk);
        start = 1'b1;
        cfg_num_tiles = 16'd1;
        cfg_num_iters = 16'd1;
        cfg_num_reads_per_iter = 16'd1;
        up_valid = 1'b1;
        acc_avail_out = 1'b0;
        acc_valid_out = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("wdog_cfg", acc_configure, 1);
        got_done = 0;
        run_cycles = 0;
        for (int c = 0; c < 100 && !got_done; c++) begin
            @(negedge clk);
            #1;
            if (done) got_done = 1;
            else if (busy) run_cycles++;
        end
        check("wdog_done", got_done, 1);
        check("wdog_cycles", run_cycles, 16);
        check("wdog_error", error, 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("wdog_error_sticky", error, 1);
        rst = 1'b0;
        #1;
        check("wdog_error_cleared", error, 0);
        @(negedge clk);
        rst = 1'b1;
`else
        got_done = 0;
        run_cycles = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/acc_job_sequencer.md
Name: acc_job_sequencer

Overview:
- Sequences the accumulator block over a list of tiles: one configure pulse per tile, then meters exactly num_iters*num_reads_per_iter input beats into it.
- Counts the num_reads_per_iter result beats and reconfigures the accumulator for the next tile.
- Sits between the upstream producer, the control/host start logic and the accumulator's configure and IN interfaces.
- Monitors the accumulator's OUT valid; it does not touch the OUT data.

Parameters:
- LOG_MAX_ITERS, 16, width of the iterations field (matches the accumulator).
- LOG_MAX_READS_PER_ITER, 16, width of the reads-per-iteration field (matches the accumulator).
- LOG_MAX_TILES, 16, width of the tile count.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle job start request
- cfg_num_tiles  in  LOG_MAX_TILES  tiles in the job
- cfg_num_iters  in  LOG_MAX_ITERS  iterations per tile
- cfg_num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  reads per iteration
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- error  out  1  sticky watchdog error
- tile_idx  out  LOG_MAX_TILES  index of the current tile, counting from 0
- acc_configure  out  1  configure pulse to the accumulator
- acc_num_iters  out  LOG_MAX_ITERS  registered config value to the accumulator
- acc_num_reads_per_iter  out  LOG_MAX_READS_PER_ITER  registered config value to the accumulator
- up_valid  in  1  upstream data valid
- up_avail  out  1  avail back to upstream
- acc_valid_in  out  1  gated valid to the accumulator IN interface
- acc_avail_out  in  1  accumulator IN avail
- acc_valid_out  in  1  accumulator OUT valid (each asserted cycle is one transferred beat)

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs and counters go to 0, including error.
- FSM states: IDLE, CONFIG, RUN, DONE.
- IDLE:
  - busy=0 and the input gate is closed.
  - On start=1: latch the three cfg fields.
  - If any cfg field is 0: go to DONE with no configure pulse.
  - Otherwise: go to CONFIG and set tile_idx=0.
- CONFIG (exactly 1 cycle):
  - acc_configure=1; acc_num_iters and acc_num_reads_per_iter hold the latched values.
  - Load in_cnt = iters*reads. in_cnt is LOG_MAX_ITERS+LOG_MAX_READS_PER_ITER bits wide, so the product never truncates.
  - Load out_cnt = reads.
  - Go to RUN.
- RUN:
  - gate = (in_cnt != 0).
  - acc_valid_in = up_valid & gate.
  - up_avail = acc_avail_out & gate.
  - in_cnt decrements on up_valid & acc_avail_out & gate.
  - out_cnt decrements on acc_valid_out.
  - When out_cnt is 1 and acc_valid_out=1 (last output beat of the tile):
    - If tile_idx == num_tiles-1: go to DONE.
    - Otherwise: increment tile_idx and go to CONFIG in the next cycle.
  - The next configure therefore never coincides with an accumulator output beat.
  - The input gate stays closed after in_cnt reaches 0, so beats of the next tile never enter the accumulator before its reconfigure.
- DONE (1 cycle):
  - done=1, busy=0, then go to IDLE.
- busy=1 in CONFIG and RUN.
- start is ignored outside IDLE.
- acc_configure is 1 only in CONFIG.
- acc_valid_out outside RUN is ignored and not counted.
- Simultaneous input and output beats in one cycle both count.
- A reset mid-job aborts immediately: no done pulse; the next start begins a fresh job.
- Latency from start to acc_configure is 1 cycle. Latency from the last output beat to done is 1 cycle.

Optional Feature:
- Macro: ACC_SEQ_TIMEOUT_EN.
- When defined:
  - In RUN, a watchdog counter resets on any input or output beat and otherwise increments.
  - On reaching TIMEOUT_CYCLES: error<=1 (sticky until reset), the gate closes, and the FSM goes to DONE (done pulses).
- When not defined:
  - No watchdog logic is built.
  - error is tied to 0.

Test Plan:
- start with tiles=1, iters=2, reads=3, up_valid and acc_avail_out held 1, accumulator model attached:
  - one acc_configure pulse;
  - exactly 6 acc_valid_in beats;
  - 3 output beats;
  - done 1 cycle after the 3rd output beat;
  - busy low afterwards.
- tiles=3, iters=1, reads=4, upstream offering 20 beats:
  - 3 configure pulses, each one cycle after the 4th output beat of the previous tile;
  - tile_idx steps 0,1,2;
  - exactly 12 beats accepted and up_avail=0 whenever the gate is closed.
- start with iters=0:
  - no acc_configure;
  - done one cycle after start;
  - busy never asserts.
- Random acc_avail_out and up_valid toggling, tiles=2, iters=4, reads=5:
  - accepted beats equal 40 total;
  - never more than 20 before the second configure pulse.
- Drop rst mid-RUN after 7 beats:
  - all outputs 0 immediately (asynchronous);
  - a new start with tiles=1, iters=1, reads=2 completes normally.
- ACC_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, acc_avail_out held 0 in RUN:
  - error=1 and done pulse after 16 idle cycles;
  - error stays 1 across a subsequent start.
